// File: rtl/puf_seq_pkg.sv
// Shared definitions for the RO-PUF challenge sequencer.
//  - default parameter values
//  - FSM state encoding (IDLE, PRST, EVAL, SAMPLE, DONE)
//  - chal_of(seed, i): nibble-wise challenge generation, no carry between nibbles
package puf_seq_pkg;

  localparam int N_BITS_DEF      = 16;
  localparam int RST_CYCLES_DEF  = 4;
  localparam int EVAL_CYCLES_DEF = 2**23;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRST   = 3'd1;
  localparam logic [2:0] ST_EVAL   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PRST   = ST_PRST,
    EVAL   = ST_EVAL,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;

  // Each nibble advances independently and wraps mod 16.
  function automatic logic [7:0] chal_of(input logic [7:0] seed, input logic [3:0] i);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = seed[3:0] + i;
    hi = seed[7:4] + i;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/puf_challenge_seq_sync.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
// Ports:
//  clk  in  system clock
//  rst  in  synchronous active-low reset (both flops clear to 0)
//  d    in  asynchronous input
//  q    out synchronized output, two clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_challenge_seq.sv
// puf_challenge_seq: challenge sequencer / response reader for the 16-bit RO PUF.
// A run issues N_BITS challenges; each one is PRST (PUF reset, RST_CYCLES),
// EVAL (enable, EVAL_CYCLES), SAMPLE (capture synchronized puf_out), then
// DONE pulses resp_valid for one cycle.
//
// Optional build macro: PUF_SEQ_MAJORITY_EN -- every challenge is evaluated
// three times and response[i] takes the 2-of-3 majority.
//
// Ports:
//  clk, rst        clock; synchronous active-low reset
//  start, seed     run request (ignored while busy) and challenge base
//  puf_rst         active-high PUF counter reset
//  puf_in_valid    PUF evaluation enable
//  puf_challenge   {bank-2 select, bank-1 select}
//  puf_out         PUF response bit (asynchronous)
//  response        assembled response, bit i from challenge i
//  resp_valid      one-cycle completion pulse
//  busy            accepted start through resp_valid cycle
module puf_challenge_seq
  import puf_seq_pkg::*;
#(
  parameter int N_BITS      = N_BITS_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter int EVAL_CYCLES = EVAL_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        seed,
  output logic              puf_rst,
  output logic              puf_in_valid,
  output logic [7:0]        puf_challenge,
  input  logic              puf_out,
  output logic [N_BITS-1:0] response,
  output logic              resp_valid,
  output logic              busy
);

  localparam int CNT_MAX = (RST_CYCLES > EVAL_CYCLES) ? RST_CYCLES : EVAL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(N_BITS - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    seed_q;
  logic [7:0]    chal;
  logic          puf_out_sync;
  logic          last_bit;
  logic          last_pass;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_out),
    .q   (puf_out_sync)
  );

  assign last_bit      = (bit_idx == BIT_LAST);
  assign puf_challenge = chal;

`ifdef PUF_SEQ_MAJORITY_EN
  logic [1:0] pass;
  logic [1:0] vote;
  assign last_pass = (pass == 2'd2);
`else
  assign last_pass = 1'b1;
`endif

  // Next state and Moore outputs
  always_comb begin
    state_d      = state;
    puf_rst      = 1'b1;
    puf_in_valid = 1'b0;
    resp_valid   = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = PRST;
      end
      PRST: begin
        if (cnt == RST_LAST) state_d = EVAL;
      end
      EVAL: begin
        puf_rst      = 1'b0;
        puf_in_valid = 1'b1;
        if (cnt == EVAL_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        puf_rst = 1'b0;
        state_d = (last_pass && last_bit) ? DONE : PRST;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      seed_q   <= '0;
      chal     <= '0;
      response <= '0;
`ifdef PUF_SEQ_MAJORITY_EN
      pass     <= '0;
      vote     <= '0;
`endif
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (start) begin
            seed_q   <= seed;
            response <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            chal     <= chal_of(seed, 4'd0);
`ifdef PUF_SEQ_MAJORITY_EN
            pass     <= '0;
            vote     <= '0;
`endif
          end
        end
        PRST:  cnt <= (cnt == RST_LAST)  ? '0 : cnt + CW'(1);
        EVAL:  cnt <= (cnt == EVAL_LAST) ? '0 : cnt + CW'(1);
        SAMPLE: begin
`ifdef PUF_SEQ_MAJORITY_EN
          if (last_pass) begin
            // 2-of-3: at least two ones among vote (0..2) plus this sample
            response[bit_idx] <= vote[1] | (vote[0] & puf_out_sync);
            pass              <= '0;
            vote              <= '0;
            bit_idx           <= bit_idx + 4'd1;
            if (!last_bit) chal <= chal_of(seed_q, bit_idx + 4'd1);
          end else begin
            vote <= vote + {1'b0, puf_out_sync};
            pass <= pass + 2'd1;
          end
`else
          response[bit_idx] <= puf_out_sync;
          bit_idx           <= bit_idx + 4'd1;
          // Challenge only changes on entry to the next PRST
          if (!last_bit) chal <= chal_of(seed_q, bit_idx + 4'd1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_seq.sv
// Randomized scoreboard bench for puf_challenge_seq (N_BITS=16, RST=2, EVAL=8).
// A behavioural PUF answers from the presented challenge; the expected
// response word and completion cycle are queued at start and checked by a
// monitor on resp_valid.
module tb_puf_challenge_seq;

  localparam int N = 16;
  localparam int R = 2;
  localparam int E = 8;
`ifdef PUF_SEQ_MAJORITY_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif
  localparam int LAT = 1 + N * P * (R + E + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   seed = 8'h00;
  logic         puf_out = 1'b0;
  logic         puf_rst, puf_in_valid, resp_valid, busy;
  logic [7:0]   puf_challenge;
  logic [N-1:0] response;

  puf_challenge_seq #(.N_BITS(N), .RST_CYCLES(R), .EVAL_CYCLES(E)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .seed          (seed),
    .puf_rst       (puf_rst),
    .puf_in_valid  (puf_in_valid),
    .puf_challenge (puf_challenge),
    .puf_out       (puf_out),
    .response      (response),
    .resp_valid    (resp_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [N-1:0] resp;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   tbl[256];
  int   mode = 0;      // 0: lo<hi, 1: challenge[4], 2: table, 3: table + late toggle, 4: table with pass-1 inverted
  int   seed_cur = 0;
  int   chk_idle_cyc = -1;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [7:0] chal_ref(input int s, input int b);
    int lo, hi;
    lo = (s % 16 + b) % 16;
    hi = (s / 16 + b) % 16;
    return 8'(hi * 16 + lo);
  endfunction

  function automatic bit model_bit(input int m, input logic [7:0] c);
    case (m)
      0:       return c[3:0] < c[7:4];
      1:       return c[4];
      default: return tbl[c];
    endcase
  endfunction

  // Behavioural PUF
  int ev_cnt = 0;
  int ev_starts = 0;
  always @(posedge clk) begin
    bit t;
    #1;
    if (puf_in_valid) ev_cnt++; else ev_cnt = 0;
    if (!busy) ev_starts = 0;
    else if (puf_in_valid && ev_cnt == 1) ev_starts++;
    t = model_bit(mode, puf_challenge);
    if (mode == 3 && ev_cnt == E) t = ~t;                       // flip in last EVAL cycle
    if (mode == 4 && ev_starts > 0 && (ev_starts - 1) % 3 == 1) t = ~t;
    puf_out = t;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  bit rst_pend = 1'b0;
  always @(negedge clk) begin
    if (rst_pend) begin
      chk("rst_puf_rst", 32'(puf_rst), 32'd1);
      chk("rst_puf_in_valid", 32'(puf_in_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_response", 32'(response), 32'd0);
      chk("rst_challenge", 32'(puf_challenge), 32'd0);
    end
    rst_pend = !rst;
    if (!rst) exp_q.delete();
    if (cyc == chk_idle_cyc) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_puf_rst", 32'(puf_rst), 32'd1);
    end
    if (rst && busy && puf_in_valid && ev_cnt == 1)
      chk("challenge", 32'(puf_challenge), 32'(chal_ref(seed_cur, (ev_starts - 1) / P)));
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_resp_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("response", 32'(response), 32'(e.resp));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 4) begin
      n_cmp++; n_err++;
      $display("FAIL resp_valid_timeout: got none expected at cycle %0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  task automatic issue(input int s, input int m);
    exp_t e;
    mode = m;
    @(posedge clk); #1;
    seed_cur = s;
    seed = 8'(s);
    for (int b = 0; b < N; b++) e.resp[b] = model_bit(m, chal_ref(s, b));
    e.cyc = cyc + LAT;
    exp_q.push_back(e);
    start = 1'b1;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < LAT + 40) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
    end
  endtask

  task automatic run(input int s, input int m, input bit hold_start);
    issue(s, m);
    if (hold_start) begin
      do begin
        @(posedge clk); #1;
        start = busy;
      end while (busy);
      chk_idle_cyc = cyc + 2;
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 1'($urandom_range(0, 1));
    // Reset with start asserted: reset wins
    rst = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run(8'h00, 0, 1'b0);
    run(8'h30, 1, 1'b0);
    for (int r = 0; r < 4; r++) run(int'($urandom_range(0, 255)), 2, 1'b0);
    run(int'($urandom_range(0, 255)), 3, 1'b0);
    run(int'($urandom_range(0, 255)), 2, 1'b1);
`ifdef PUF_SEQ_MAJORITY_EN
    run(int'($urandom_range(0, 255)), 4, 1'b0);
`endif

    // Abort during EVAL of bit 5
    issue(int'($urandom_range(0, 255)), 2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      if (ev_starts == 5 * P + 1 && ev_cnt == 3) break;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (LAT + 10) @(posedge clk);

    // Recovery after abort
    run(int'($urandom_range(0, 255)), 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
